// File: rtl/vga_pattern_sequencer_pkg.sv
// Shared definitions for the VGA test-pattern path.
//   - sequencer FSM state encodings (2-bit, legacy-compatible constants)
//   - 640x480@60 timing constants shared with the timing generator
//   - pattern index constants understood by the pixel generator
package vga_pkg;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t S_RUN   = 2'd0;
  localparam seq_state_t S_PEND  = 2'd1;
  localparam seq_state_t S_BLANK = 2'd2;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned PAT_COLOR_BAR = 0;
  localparam int unsigned PAT_GRAY_RAMP = 1;
  localparam int unsigned PAT_CHECKER   = 2;
  localparam int unsigned PAT_GRID      = 3;
  localparam int unsigned PAT_RED       = 4;
  localparam int unsigned PAT_GREEN     = 5;
  localparam int unsigned PAT_BLUE      = 6;
  localparam int unsigned PAT_WHITE     = 7;

endpackage

// File: rtl/vga_pattern_sequencer_if.sv
// Link between the sequencer and the timing/pixel generator.
//   I_frame_start  : 1-cycle pulse from the timing generator at h=v=0
//   O_pattern_sel  : current pattern index
//   O_blank_req    : pixel generator must output black
//   O_mode_auto    : auto-advance mode active
//   O_busy         : a pattern switch is pending or blanking
// master = timing/pixel side, slave = sequencer.
interface vga_pattern_sequencer_if #(
  parameter int PAT_W = 3
) ();
  logic             I_frame_start;
  logic [PAT_W-1:0] O_pattern_sel;
  logic             O_blank_req;
  logic             O_mode_auto;
  logic             O_busy;

  modport master (
    output I_frame_start,
    input  O_pattern_sel, O_blank_req, O_mode_auto, O_busy
  );

  modport slave (
    input  I_frame_start,
    output O_pattern_sel, O_blank_req, O_mode_auto, O_busy
  );
endinterface

// File: rtl/vga_pattern_sequencer_btn_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a debouncer.
//   I_clk, I_rst_n : clock, async active-low reset
//   I_btn          : raw asynchronous bouncing button
//   O_level        : debounced level
//   O_rise         : 1-cycle pulse on a 0->1 change of O_level
// The level follows the synchronised input after DEBOUNCE_CYCLES
// consecutive samples that differ from the current level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_btn,
  output logic O_level,
  output logic O_rise
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      O_level <= 1'b0;
      O_rise  <= 1'b0;
    end else begin
      sync   <= {sync[0], I_btn};
      O_rise <= 1'b0;
      if (sync[1] != O_level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          O_level <= sync[1];
          O_rise  <= sync[1];
          cnt     <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        // A sample matching the accepted level restarts the run.
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/vga_pattern_sequencer.sv
// Test-pattern sequencer: chooses the pattern index for the pixel
// generator and switches it only on frame boundaries.
//   I_clk, I_rst_n : 50 MHz clock, async active-low reset
//   I_btn_next     : raw button, advance pattern (manual)
//   I_btn_mode     : raw button, toggle manual/auto
//   vid            : frame_start in; pattern_sel/blank_req/mode_auto/busy out
// Auto mode advances every AUTO_FRAMES frames spent in S_RUN. A switch
// waits for the next frame start, then optionally blanks BLANK_FRAMES
// frames before the index increments. Requests while busy are dropped.
module vga_pattern_sequencer
  import vga_pkg::*;
#(
  parameter int NUM_PATTERNS    = 8,
  parameter int PAT_W           = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_FRAMES     = 120,
  parameter int BLANK_FRAMES    = 2
) (
  input  logic                    I_clk,
  input  logic                    I_rst_n,
  input  logic                    I_btn_next,
  input  logic                    I_btn_mode,
  vga_pattern_sequencer_if.slave  vid
);
  localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam int BW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

  seq_state_t    state, state_nxt;
  logic [AW-1:0] auto_cnt;
  logic [BW-1:0] blank_cnt;
  logic          next_pulse, mode_pulse;
  logic          next_level, mode_level;
  logic          in_run, auto_req, req, pat_inc;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_btn   (I_btn_next),
    .O_level (next_level),
    .O_rise  (next_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_btn   (I_btn_mode),
    .O_level (mode_level),
    .O_rise  (mode_pulse)
  );

  always_comb begin
    in_run    = (state == S_RUN);
    auto_req  = vid.O_mode_auto && in_run && vid.I_frame_start &&
                (auto_cnt == AW'(AUTO_FRAMES - 1));
    req       = next_pulse | auto_req;
    state_nxt = state;
    pat_inc   = 1'b0;
    case (state)
      S_RUN: begin
        if (req) state_nxt = S_PEND;
      end
      S_PEND: begin
        if (vid.I_frame_start) begin
          if (BLANK_FRAMES == 0) begin
            pat_inc   = 1'b1;
            state_nxt = S_RUN;
          end else begin
            state_nxt = S_BLANK;
          end
        end
      end
      S_BLANK: begin
        if (vid.I_frame_start && blank_cnt == BW'(1)) begin
          pat_inc   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state             <= S_RUN;
      blank_cnt         <= '0;
      auto_cnt          <= '0;
      vid.O_pattern_sel <= '0;
      vid.O_blank_req   <= 1'b0;
      vid.O_mode_auto   <= 1'b0;
      vid.O_busy        <= 1'b0;
    end else begin
      state           <= state_nxt;
      vid.O_busy      <= (state_nxt != S_RUN);
      // Blanking is exactly the time spent in S_BLANK, registered.
      vid.O_blank_req <= (state_nxt == S_BLANK);
      vid.O_mode_auto <= vid.O_mode_auto ^ mode_pulse;

      if (state == S_PEND && vid.I_frame_start)
        blank_cnt <= BW'(BLANK_FRAMES);
      else if (state == S_BLANK && vid.I_frame_start)
        blank_cnt <= blank_cnt - BW'(1);

      if (pat_inc) begin
        if (vid.O_pattern_sel == PAT_W'(NUM_PATTERNS - 1))
          vid.O_pattern_sel <= '0;
        else
          vid.O_pattern_sel <= vid.O_pattern_sel + PAT_W'(1);
      end

      // Mode toggle and an accepted manual advance both restart the count.
      if (mode_pulse || (next_pulse && in_run))
        auto_cnt <= '0;
      else if (vid.O_mode_auto && in_run && vid.I_frame_start)
        auto_cnt <= auto_req ? '0 : auto_cnt + AW'(1);
    end
  end
endmodule
